// File: rtl/imm_ext_pipe.sv
// Immediate-extension unit with a DEPTH-entry output FIFO: sign, zero, upper or
// branch-offset form, computed at accept and stored alongside the mode.
module imm_ext_pipe #(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int BR_SHIFT = 2,
  parameter int DEPTH    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IN_W-1:0]          in_imm,
  input  logic [1:0]               in_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic [1:0]               out_mode,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (OUT_W <= IN_W) begin : g_chk_width
    $error("imm_ext_pipe: OUT_W must exceed IN_W");
  end
  if (OUT_W - IN_W < BR_SHIFT) begin : g_chk_shift
    $error("imm_ext_pipe: OUT_W-IN_W must be >= BR_SHIFT");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
    $error("imm_ext_pipe: DEPTH must be a power of two >= 2");
  end

  logic [OUT_W-1:0] mem_data [DEPTH];
  logic [1:0]       mem_mode [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_q;
  logic [OUT_W-1:0] last_data;
  logic [1:0]       last_mode;

  logic [OUT_W-1:0] ext_sign, ext_val;
  logic             push, pop;

  assign ext_sign = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};

  always_comb begin
    ext_val = ext_sign;
    case (in_mode)
      2'b00: ext_val = ext_sign;
      2'b01: ext_val = {{(OUT_W-IN_W){1'b0}}, in_imm};
      2'b10: ext_val = {in_imm, {(OUT_W-IN_W){1'b0}}};
      2'b11: ext_val = ext_sign << BR_SHIFT;
      default: ext_val = ext_sign;
    endcase
  end

  assign in_ready  = (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_mode[i] <= '0;
      end
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      last_data <= '0;
      last_mode <= '0;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= ext_val;
        mem_mode[wr_ptr] <= in_mode;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop) begin
        last_data <= mem_data[rd_ptr];
        last_mode <= mem_mode[rd_ptr];
        rd_ptr    <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // when drained, keep presenting the last popped entry rather than stale storage
  assign out_data = out_valid ? mem_data[rd_ptr] : last_data;
  assign out_mode = out_valid ? mem_mode[rd_ptr] : last_mode;
  assign count    = count_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed bench for imm_ext_pipe with default parameters; expected values are
// hand-computed constants.
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_mode;
  logic [1:0]  count;

  int n_checks = 0;
  int n_fails  = 0;

  imm_ext_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mode  (out_mode),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // push one entry with out_ready=1, check it appears next cycle and drains after
  task automatic push_check(input string tag, input logic [15:0] imm,
                            input logic [1:0] mode, input logic [31:0] exp);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_imm    = imm;
    in_mode   = mode;
    step();
    in_valid  = 1'b0;
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"},  out_data, exp);
    chk({tag, "_mode"},  32'(out_mode), 32'(mode));
    step();
    chk({tag, "_drained"}, 32'(count), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_imm    = '0;
    in_mode   = '0;
    out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data",  out_data, 32'h0);
    chk("rst_mode",  32'(out_mode), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // T1..T3 extension forms
    push_check("t1_sign",   16'h8001, 2'b00, 32'hFFFF8001);
    push_check("t2_zero",   16'h8001, 2'b01, 32'h00008001);
    push_check("t2_upper",  16'h1234, 2'b10, 32'h12340000);
    push_check("t3_br_neg", 16'hFFFF, 2'b11, 32'hFFFFFFFC);
    push_check("t3_br_pos", 16'h0003, 2'b11, 32'h0000000C);
    chk("empty_holds_last", out_data, 32'h0000000C);

    // T4 fill with consumer stalled
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_imm = 16'h0010; in_mode = 2'b00;
    step();
    chk("t4_count1", 32'(count), 32'd1);
    chk("t4_ready1", 32'(in_ready), 32'd1);
    in_imm = 16'hFFF0; in_mode = 2'b01;
    step();
    chk("t4_count2", 32'(count), 32'd2);
    chk("t4_full_ready", 32'(in_ready), 32'd0);
    in_imm = 16'h7777; in_mode = 2'b10;
    step();
    chk("t4_count_hold", 32'(count), 32'd2);
    chk("t4_ready_hold", 32'(in_ready), 32'd0);
    in_valid  = 1'b0;
    in_imm    = 16'h5555;
    out_ready = 1'b1;
    chk("t4_head0", out_data, 32'h00000010);
    step();
    chk("t4_count_pop", 32'(count), 32'd1);
    chk("t4_ready_after_pop", 32'(in_ready), 32'd1);
    chk("t4_head1", out_data, 32'h0000FFF0);
    chk("t4_head1_mode", 32'(out_mode), 32'd1);
    step();
    chk("t4_empty", 32'(count), 32'd0);
    chk("t4_no_third", 32'(out_valid), 32'd0);
    chk("t4_last", out_data, 32'h0000FFF0);

    // T5 steady push & pop at count=1 across pointer wrap
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_imm = 16'h00FF; in_mode = 2'b01;
    step();
    chk("t5_prime", 32'(count), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_imm = 16'h0100 + 16'(i);
      step();
      chk($sformatf("t5_count_%0d", i), 32'(count), 32'd1);
      chk($sformatf("t5_data_%0d", i), out_data, 32'h00000100 + 32'(i));
    end
    in_valid = 1'b0;
    step();
    chk("t5_drained", 32'(count), 32'd0);

    // T6 async reset with two entries queued
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_imm = 16'hABCD; in_mode = 2'b10;
    step();
    step();
    in_valid = 1'b0;
    chk("t6_full", 32'(count), 32'd2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_count", 32'(count), 32'd0);
    chk("t6_rst_data",  out_data, 32'h0);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    chk("t6_in_ready", 32'(in_ready), 32'd1);
    chk("t6_no_emit", 32'(out_valid), 32'd0);
    push_check("t6_post", 16'h4000, 2'b00, 32'h00004000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
